// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 UART receiver. The asynchronous serial line is synchronized, and then
// sampled at the middle of each bit using a clock-cycle counter derived from
// CLK_FREQ/BAUD_RATE. Completed frames are presented on a byte-wide port
// together with a one-cycle strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst_       asynchronous, active-high reset
//   rx_serial  serial line, idle high, asynchronous to clk
//   rx_data    last received byte; it is updated only when a frame completes
//   rx_valid   one-cycle pulse: a good frame was received
//   rx_error   one-cycle pulse: framing error (the stop bit was sampled low)
//
// DIVISOR (clocks per bit) must be at least 4.
module uart_rx_core #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(DIVISOR) + 1;

  // The counter starts at 0 when a phase is entered. A sample is therefore
  // taken on the cycle where the count equals the phase length minus one.
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      idx_reg;
  logic [7:0]      shift_reg;
  logic [1:0]      sync_reg;
  logic            rxs;

  // Two-flop synchronizer. Reset loads the idle level so that leaving reset
  // is never mistaken for a start edge.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx_serial};
    end
  end

  assign rxs = sync_reg[1];

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      // The strobes are high for a single cycle only.
      rx_valid <= 1'b0;
      rx_error <= 1'b0;

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rxs) begin
            state_reg <= START;
          end
        end

        // Check the start bit again at its midpoint. This filters out glitches
        // and also puts every later sample at the middle of its bit.
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            if (!rxs) begin
              state_reg <= DATA;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg            <= '0;
            shift_reg[idx_reg] <= rxs;
            if (idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        // The receiver returns to IDLE at the middle of the stop bit. The
        // second half of the stop bit is therefore already free for the next
        // start edge.
        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            rx_data <= shift_reg;
            if (rxs) begin
              rx_valid  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              rx_error  <= 1'b1;
              state_reg <= WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        // After a framing error, a break or a held-low line must not be
        // decoded as a new start bit. Wait here until the line goes high.
        WAIT_IDLE: begin
          cnt_reg <= '0;
          if (rxs) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  localparam int CLK_FREQ  = 3_200_000;
  localparam int BAUD_RATE = 100_000;
  localparam int D         = CLK_FREQ / BAUD_RATE;   // 32 clocks per bit

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       rst_;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   both_cnt = 0;
  int   hold_cnt = 0;
  int   last_pulse_cyc = 0;
  logic [7:0] last_data = 8'h00;
  ev_t  got_q[$];
  ev_t  exp_q[$];

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .rx_serial(rx_serial),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every completion event, and check that the outputs
  // behave as required between events.
  always @(negedge clk) begin
    if (rst_) begin
      last_data = 8'h00;
    end else begin
      if (rx_valid && rx_error) both_cnt++;
      if (rx_valid || rx_error) begin
        got_q.push_back({rx_error, rx_data});
        last_pulse_cyc = cyc;
        last_data = rx_data;
      end else if (rx_data !== last_data) begin
        hold_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model of one frame: the stop-bit level alone decides whether the
  // frame is good or a framing error. The byte is reported in both cases.
  task automatic push_exp(input logic [7:0] d, input logic stop);
    ev_t e;
    e.err  = ~stop;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic line_bit(input logic v, input int n);
    rx_serial = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    line_bit(1'b0, D);
    for (int i = 0; i < 8; i++) line_bit(d[i], D);
    line_bit(stop, D);
  endtask

  task automatic check_events(input string tag);
    ev_t e;
    ev_t g;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_kind"}, {31'd0, g.err}, {31'd0, e.err});
      chk({tag, "_data"}, {24'd0, g.data}, {24'd0, e.data});
      $display("event %s kind=%0d data=%02h expected kind=%0d data=%02h", tag, g.err, g.data, e.err, e.data);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int t0;
    logic [7:0] b;
    rst_      = 1'b1;
    rx_serial = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_ = 1'b0;

    // With the line idle, all outputs stay in their reset state.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_valid", rx_valid, 0);
      chk("idle_error", rx_error, 0);
      chk("idle_data", rx_data, 8'h00);
    end
    @(posedge clk);
    #1;

    // All-ones frame, then all-zeros frame. Also check the latency from the
    // start edge to the strobe.
    t0 = cyc;
    send_frame(8'hFF, 1'b1);
    push_exp(8'hFF, 1'b1);
    chk("latency", 32'(last_pulse_cyc - t0), 32'((19 * D) / 2 + 3));
    line_bit(1'b1, D);
    check_events("ff");

    send_frame(8'h00, 1'b1);
    push_exp(8'h00, 1'b1);
    line_bit(1'b1, D);
    check_events("zero");

    // Random bytes. Each next start edge comes one bit time after the strobe.
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      push_exp(b, 1'b1);
      line_bit(1'b1, D / 2);
    end
    line_bit(1'b1, D);
    check_events("rand");

    // False start: a short low pulse gives no event, and a good frame follows.
    line_bit(1'b0, 10);
    line_bit(1'b1, 2 * D);
    check_events("false_start");
    send_frame(8'hA5, 1'b1);
    push_exp(8'hA5, 1'b1);
    line_bit(1'b1, D);
    check_events("after_false");

    // Bad stop bit, with the line held low. Expect exactly one error event.
    send_frame(8'hFF, 1'b0);
    push_exp(8'hFF, 1'b0);
    line_bit(1'b0, 2 * D);
    line_bit(1'b1, 2 * D);
    check_events("bad_stop");
    chk("bad_stop_data", rx_data, 8'hFF);
    send_frame(8'h3C, 1'b1);
    push_exp(8'h3C, 1'b1);
    line_bit(1'b1, D);
    check_events("after_bad");

    // Reset in the middle of a frame, after bit 3 has been sampled.
    b = 8'hC3;
    line_bit(1'b0, D);
    for (int i = 0; i < 5; i++) line_bit(b[i], D);
    rst_      = 1'b1;
    rx_serial = 1'b1;
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_error", rx_error, 0);
    chk("rst_data", rx_data, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b0;
    line_bit(1'b1, 2 * D);
    check_events("mid_reset");
    send_frame(8'h5A, 1'b1);
    push_exp(8'h5A, 1'b1);
    line_bit(1'b1, D);
    check_events("after_reset");

    chk("never_both", both_cnt, 0);
    chk("data_hold", hold_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1 UART receiver. Converts the asynchronous serial input into parallel bytes: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity.
- Sits behind the board-level RX pin and feeds a byte-wide consumer with a one-cycle valid strobe.
- Bit timing comes from a clock-cycle counter derived from CLK_FREQ/BAUD_RATE; there is no external baud tick.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- DIVISOR (localparam), CLK_FREQ/BAUD_RATE with integer truncation (434 at defaults), clocks per bit. Must be >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_  input  1  reset, asynchronous, active-high.
- rx_serial  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse: good frame received.
- rx_error  output  1  one-cycle pulse: framing error (stop bit sampled low).

Behaviour:
- Reset (async, rst_=1): state IDLE, all counters cleared, rx_data=8'h00, rx_valid=0, rx_error=0, synchronizer flops set to 1 (idle level). Reset mid-frame aborts the frame with no pulse.
- Input conditioning: rx_serial passes through a 2-flop synchronizer. All sampling uses the synchronized value (rxs).
- Clock counter: a bit counter of width clog2(DIVISOR)+1 restarts at the start edge. Each sample point sits mid-bit.
- States:
  - IDLE: wait for rxs=0 (falling edge of the line) -> START, counter cleared.
  - START: after DIVISOR/2 (integer) clocks, sample rxs. If rxs=0 -> DATA with bit index 0 and counter cleared. If rxs=1 (glitch or false start) -> IDLE with no pulse.
  - DATA: every DIVISOR clocks, sample rxs into shift register bit[index] (LSB first). After index 7 is sampled -> STOP.
  - STOP: after DIVISOR clocks, sample rxs.
    - rxs=1: load rx_data with the shift register and pulse rx_valid for exactly 1 cycle -> IDLE.
    - rxs=0: load rx_data with the shift register and pulse rx_error for exactly 1 cycle -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1, then -> IDLE. This prevents a held-low/break line from being decoded as a new start bit.
- Latency: the valid/error pulse occurs in the cycle after the stop-bit sample, about 9.5*DIVISOR + 3 clocks after the line's falling start edge.
- rx_valid and rx_error are never asserted together. Both are 0 in every other cycle.
- rx_data holds its value between frames and changes only on a valid or error completion.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start edge arriving 0.5 bit later or any time after is accepted.
- Line activity in DATA/STOP is sampled only at mid-bit points; there is no resync inside a frame.
- Counters reload exactly, with no drift accumulation beyond the DIVISOR truncation.

Test Plan:
- Reset, line idle high for 100 clocks -> rx_valid=0, rx_error=0, rx_data=8'h00 throughout.
- Send 8'hFF, then 8'h00 at BAUD_RATE, stop bit 1 -> one rx_valid pulse per frame, rx_data=8'hFF then 8'h00, rx_error never 1.
- 5-10 random bytes back-to-back, next frame starting one bit time after each valid -> one rx_valid per byte, rx_data matches each byte in order.
- False start: line low 10 clocks then high for 2 bit times -> no rx_valid, no rx_error, state back in IDLE. A following good frame of 8'hA5 is received correctly.
- Bad stop: start, data 8'hFF, stop bit 0, line held low 2 bit times then high -> exactly one rx_error pulse, rx_data=8'hFF, no rx_valid, no spurious second frame. A following frame of 8'h3C is received correctly.
- Assert rst_ mid-frame (after bit 3) -> outputs cleared immediately, no pulse. After release, a new frame of 8'h5A is received correctly.
